// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite read arbiter slice.
//   axil_rd_state_e : read-sequencer FSM state (IDLE -> ADDR -> DATA -> RESP)
//   RESP_*          : AXI RRESP encodings
//   ARPROT_DEFAULT  : protection attributes driven on every read address
package axil_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } axil_rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index of the most recent grant; search starts at ptr+1 and wraps
//   gnt : one-hot grant (all zero when no request)
//   idx : encoded index of the granted bit
//   any : at least one request present
// The pointer register lives in the parent.
module axil_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic          hi_found;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Two passes over a fixed-order loop: the first set bit strictly above
    // ptr wins; failing that, the lowest set bit overall (the wrap case).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        any      = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i] && !any) begin
                any    = 1'b1;
                lo_idx = IW'(i);
            end
            if (req[i] && (IW'(i) > ptr) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
        end
        idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        gnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (any && (IW'(i) == idx)) begin
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_read_arbiter.sv
// Shares one AXI4-Lite read master channel (AR + R) among NREQ requesters.
// Round-robin grant, one outstanding read; every output is a flop.
//   ACLK, ARESETn        : clock, asynchronous active-low reset
//   req_valid/req_addr   : per-requester read requests (addr flattened, AW each)
//   req_ready            : one-cycle one-hot accept pulse
//   rsp_valid/rsp_ready  : one-hot response handshake, held until taken
//   rsp_data/rsp_resp    : returned RDATA / RRESP (unmodified)
//   AR*/R*               : AXI4-Lite read address and read data channels
module axil_read_arbiter
    import axil_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [DW-1:0]      rsp_data,
    output logic [1:0]         rsp_resp,
    output logic               ARVALID,
    input  logic               ARREADY,
    output logic [AW-1:0]      ARADDR,
    output logic [2:0]         ARPROT,
    input  logic               RVALID,
    output logic               RREADY,
    input  logic [DW-1:0]      RDATA,
    input  logic [1:0]         RRESP
);

    localparam int unsigned IW = $clog2(NREQ);

    axil_rd_state_e  state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic [AW-1:0]   addr_sel;

    axil_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req  (req_valid),
        .ptr  (ptr_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    // One-hot address mux driven straight from the grant vector.
    always_comb begin
        addr_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                addr_sel = req_addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        req_ready_d = '0;
        rsp_valid_d = rsp_valid_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready_d = arb_gnt;
                    gnt_d       = arb_gnt;
                    araddr_d    = addr_sel;
                    ptr_d       = arb_idx;
                    state_d     = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // ARVALID rises on the first ADDR cycle and is only cleared
                // by the handshake, which also raises RREADY in the same
                // edge so the two are never high together.
                if (arvalid_q && ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_DATA;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (rready_q && RVALID) begin
                    rready_d    = 1'b0;
                    rsp_data_d  = RDATA;
                    rsp_resp_d  = RRESP;
                    rsp_valid_d = gnt_q;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                // Only the granted requester's rsp_ready counts.
                if ((rsp_ready & rsp_valid_q) != '0) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IW'(NREQ - 1);
            gnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;
    assign ARVALID   = arvalid_q;
    assign ARADDR    = araddr_q;
    assign ARPROT    = ARPROT_DEFAULT;
    assign RREADY    = rready_q;

endmodule
